// File: rtl/clk_sample_scheduler_if.sv
// Handshake/bus bundle for clk_sample_scheduler. The smp_time signal exists only when
// SMP_TIMESTAMP_EN is defined.
interface clk_sample_scheduler_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] delay;
    logic [1:0]       sig_in;
    logic             busy;
    logic             slow_clk;
    logic             slow_en;
    logic             smp_valid;
    logic [1:0]       smp_data;
    logic             smp_ready;
    logic             done;
`ifdef SMP_TIMESTAMP_EN
    logic [CNT_W-1:0] smp_time;
`endif

    modport slave (
        input  start, delay, sig_in, smp_ready,
`ifdef SMP_TIMESTAMP_EN
        output smp_time,
`endif
        output busy, slow_clk, slow_en, smp_valid, smp_data, done
    );

    modport master (
        output start, delay, sig_in, smp_ready,
`ifdef SMP_TIMESTAMP_EN
        input  smp_time,
`endif
        input  busy, slow_clk, slow_en, smp_valid, smp_data, done
    );
endinterface

// File: rtl/clk_sample_scheduler.sv
// Free-running clock divider plus a one-shot timed sampler of a 2-bit input with valid/ready
// handoff. Define SMP_TIMESTAMP_EN to add a cycle-count timestamp latched with each sample.
module clk_sample_scheduler #(
    parameter int CNT_W = 16,
    parameter int DIV   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    clk_sample_scheduler_if.slave  bus
);
    localparam int              DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dly_q, dly_d;
    logic [1:0]       smp_data_q, smp_data_d;
    logic             smp_valid_q, smp_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             capture_s;

    logic [DIV_W-1:0] div_cnt_q;
    logic             slow_clk_q;
    logic             slow_en_q;
    logic             div_wrap_s;

    assign div_wrap_s = (div_cnt_q == DIV_LAST);
    assign capture_s  = (state_q == COUNT) && (cnt_q == dly_q);

    // Divider runs regardless of scheduler state; slow_en marks the registered 0->1 edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q  <= {DIV_W{1'b0}};
            slow_clk_q <= 1'b0;
            slow_en_q  <= 1'b0;
        end else begin
            div_cnt_q  <= div_wrap_s ? {DIV_W{1'b0}} : div_cnt_q + DIV_W'(1);
            slow_clk_q <= slow_clk_q ^ div_wrap_s;
            slow_en_q  <= div_wrap_s & ~slow_clk_q;
        end
    end

    // Next-state and output decode; the compare happens before the increment so dly_q may be all-ones.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dly_d       = dly_q;
        smp_data_d  = smp_data_q;
        smp_valid_d = smp_valid_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dly_d   = (bus.delay == {CNT_W{1'b0}}) ? CNT_W'(1) : bus.delay;
                    cnt_d   = CNT_W'(1);
                    state_d = COUNT;
                end else begin
                    state_d = IDLE;
                end
            end
            COUNT: begin
                if (capture_s) begin
                    smp_data_d  = bus.sig_in;
                    smp_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (smp_valid_q && bus.smp_ready) begin
                    smp_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end else begin
                    state_d = HOLD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                smp_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d == COUNT) || (state_d == HOLD);
    end

    // Scheduler state and registered outputs; reset discards any pending sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            dly_q       <= {CNT_W{1'b0}};
            smp_data_q  <= 2'b00;
            smp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dly_q       <= dly_d;
            smp_data_q  <= smp_data_d;
            smp_valid_q <= smp_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef SMP_TIMESTAMP_EN
    logic [CNT_W-1:0] ts_q;
    logic [CNT_W-1:0] smp_time_q;

    // Free-running cycle count, sampled on the same edge as sig_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q       <= {CNT_W{1'b0}};
            smp_time_q <= {CNT_W{1'b0}};
        end else begin
            ts_q       <= ts_q + CNT_W'(1);
            smp_time_q <= capture_s ? ts_q : smp_time_q;
        end
    end

    assign bus.smp_time = smp_time_q;
`endif

    assign bus.busy      = busy_q;
    assign bus.slow_clk  = slow_clk_q;
    assign bus.slow_en   = slow_en_q;
    assign bus.smp_valid = smp_valid_q;
    assign bus.smp_data  = smp_data_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_clk_sample_scheduler.sv
// Scoreboard bench for clk_sample_scheduler (DIV=1, CNT_W=16); timestamp checks follow SMP_TIMESTAMP_EN.
module tb_clk_sample_scheduler;
    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_err;
    logic [1:0] sb_q[$];

    clk_sample_scheduler_if #(.CNT_W(16)) bus ();

    clk_sample_scheduler #(.CNT_W(16), .DIV(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] pat(input int e);
        logic [31:0] v;
        v = e;
        return v[1:0] ^ v[3:2];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // sig_in present at edge number e is always pat(e).
    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
        bus.sig_in = pat(cyc + 1);
    endtask

    task automatic div_check(input int n);
        logic [31:0] rel;
        rel = 0;
        for (int i = 0; i < n; i++) begin
            tick;
            rel++;
            chk("slow_clk", bus.slow_clk, rel[0]);
            chk("slow_en", bus.slow_en, rel[0]);
            chk("idle_done", bus.done, 1'b0);
            chk("idle_valid", bus.smp_valid, 1'b0);
        end
    endtask

    task automatic do_capture(input logic [15:0] dly, input int lag, input bit noise);
        int acc;
        int eff;
        int cap;
        int k;
        logic [1:0] exp_d;
        eff = (dly == 16'd0) ? 1 : int'(dly);
        acc = cyc + 1;
        cap = acc + eff;
        bus.start = 1'b1;
        bus.delay = dly;
        sb_q.push_back(pat(cap));
        tick;
        bus.start = 1'b0;
        chk("busy_on_accept", bus.busy, 1'b1);
        k = 0;
        while (!bus.smp_valid && k < eff + 8) begin
            if (noise && k == 2) begin
                bus.start = 1'b1;
                bus.delay = 16'd3;
            end
            if (noise && k == 3) bus.start = 1'b0;
            tick;
            k++;
        end
        bus.start = 1'b0;
        if (!bus.smp_valid) begin
            chk("valid_timeout", 32'd0, 32'd1);
            sb_q.delete();
            return;
        end
        chk("valid_cycle", cyc, cap);
        exp_d = sb_q.pop_front();
        chk("smp_data", bus.smp_data, exp_d);
        for (int i = 0; i < lag; i++) begin
            tick;
            chk("hold_valid", bus.smp_valid, 1'b1);
            chk("hold_data", bus.smp_data, exp_d);
            chk("hold_busy", bus.busy, 1'b1);
        end
        bus.smp_ready = 1'b1;
        tick;
        bus.smp_ready = 1'b0;
        chk("done_pulse", bus.done, 1'b1);
        chk("valid_clear", bus.smp_valid, 1'b0);
        chk("busy_clear", bus.busy, 1'b0);
        if (noise) bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        chk("done_once", bus.done, 1'b0);
        chk("idle_after_done", bus.busy, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.delay = 16'd0;
        bus.sig_in = 2'b00;
        bus.smp_ready = 1'b0;
        #2;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_slow_clk", bus.slow_clk, 1'b0);
        chk("rst_smp_valid", bus.smp_valid, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        tick;
        tick;
        rst = 1'b0;
        div_check(8);

        do_capture(16'd8, 0, 1'b0);
        do_capture(16'd0, 0, 1'b0);
        do_capture(16'd2, 5, 1'b0);
        do_capture(16'd8, 1, 1'b1);

        // abort mid-COUNT with an asynchronous reset
        bus.start = 1'b1;
        bus.delay = 16'd8;
        sb_q.push_back(pat(cyc + 9));
        tick;
        bus.start = 1'b0;
        tick;
        tick;
        tick;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_slow_clk", bus.slow_clk, 1'b0);
        chk("arst_slow_en", bus.slow_en, 1'b0);
        chk("arst_valid", bus.smp_valid, 1'b0);
        chk("arst_data", bus.smp_data, 2'b00);
        chk("arst_done", bus.done, 1'b0);
        chk("sb_pending", sb_q.size(), 1);
        sb_q.delete();
        tick;
        tick;
        rst = 1'b0;
        div_check(10);
        do_capture(16'd5, 0, 1'b0);
`ifdef SMP_TIMESTAMP_EN
        chk("smp_time", bus.smp_time, 16'd15);
`endif
        do_capture(16'd3, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
